// File: rtl/lock_pkg.sv
// Shared types and constants for the logic-locking key controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        ARMED   = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One bit-step of a non-reflected CRC-8, data bit entering at the top.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/lock_crc8.sv
// Combinational CRC-8 signature over a full word, MSB first, zero seed.
module lock_crc8 import lock_pkg::*; #(
    parameter int DATA_W = 18
) (
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        crc
);

    logic [7:0] crc_s;

    // Unrolled bit-serial CRC walking from the MSB down to bit 0.
    always_comb begin
        crc_s = 8'h00;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            crc_s = crc8_step(crc_s, data[i]);
        end
    end

    assign crc = crc_s;

endmodule

// File: rtl/lock_key_ctrl.sv
// Serial key loader for a locked netlist: collects key chunks, checks length
// and CRC-8 signature, drives the verified key, and locks out after repeated
// failed commits.
module lock_key_ctrl import lock_pkg::*; #(
    parameter int          XOR_KEYS     = 14,
    parameter int          MUX_KEYS     = 4,
    parameter int          CHUNK_W      = 1,
    parameter int          MAX_ATTEMPTS = 3,
    parameter logic [7:0]  KEY_SIG      = 8'h00,
    localparam int         KEY_W        = XOR_KEYS + MUX_KEYS,
    localparam int         FC_W         = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_in_valid,
    output logic               key_in_ready,
    input  logic [CHUNK_W-1:0] key_in_data,
    input  logic               key_in_last,
    output logic [KEY_W-1:0]   key_out,
    output logic               key_armed,
    output logic               locked_out,
    output logic [FC_W-1:0]    fail_count
);

    localparam int N_CHUNK = KEY_W / CHUNK_W;
    localparam int CNT_W   = $clog2(N_CHUNK + 1);

    if (KEY_W % CHUNK_W != 0) begin : g_bad_chunk
        $error("lock_key_ctrl: KEY_W must be a multiple of CHUNK_W");
    end

    lock_state_t        state_r;
    logic [KEY_W-1:0]   shadow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               len_ok_r;

    logic               accept_s;
    logic [CNT_W-1:0]   cnt_base_s;
    logic [CNT_W:0]     cnt_inc_s;
    logic [KEY_W-1:0]   shadow_base_s;
    logic [KEY_W-1:0]   shifted_s;
    logic [FC_W-1:0]    fail_inc_s;
    logic [7:0]         crc_s;

    lock_crc8 #(.DATA_W(KEY_W)) u_crc (
        .data (shadow_r),
        .crc  (crc_s)
    );

    // Next shadow/counter values; a new transfer (from IDLE or ARMED) starts from empty.
    always_comb begin
        accept_s = key_in_valid & key_in_ready;
        if (state_r == LOAD) begin
            cnt_base_s    = cnt_r;
            shadow_base_s = shadow_r;
        end else begin
            cnt_base_s    = {CNT_W{1'b0}};
            shadow_base_s = {KEY_W{1'b0}};
        end
        cnt_inc_s = {1'b0, cnt_base_s} + {{CNT_W{1'b0}}, 1'b1};
        shifted_s = (shadow_base_s << CHUNK_W) | KEY_W'(key_in_data);
        if (fail_count < FC_W'(MAX_ATTEMPTS)) begin
            fail_inc_s = fail_count + {{(FC_W-1){1'b0}}, 1'b1};
        end else begin
            fail_inc_s = fail_count;
        end
    end

    // Controller FSM with all outputs registered. CHECK is a single cycle, so
    // the verdict appears on the edge after the final accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shadow_r     <= {KEY_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            len_ok_r     <= 1'b0;
            key_out      <= {KEY_W{1'b0}};
            key_armed    <= 1'b0;
            locked_out   <= 1'b0;
            fail_count   <= {FC_W{1'b0}};
            key_in_ready <= 1'b0;
        end else begin
            case (state_r)
                IDLE, LOAD, ARMED: begin
                    if (accept_s) begin
                        shadow_r  <= shifted_s;
                        key_out   <= {KEY_W{1'b0}};
                        key_armed <= 1'b0;
                        if (key_in_last) begin
                            state_r      <= CHECK;
                            len_ok_r     <= (cnt_inc_s == (CNT_W+1)'(N_CHUNK));
                            cnt_r        <= cnt_inc_s[CNT_W-1:0];
                            key_in_ready <= 1'b0;
                        end else if (cnt_base_s == CNT_W'(N_CHUNK)) begin
                            // Over-long transfer: commit it as a forced failure.
                            state_r      <= CHECK;
                            len_ok_r     <= 1'b0;
                            key_in_ready <= 1'b0;
                        end else begin
                            state_r      <= LOAD;
                            cnt_r        <= cnt_inc_s[CNT_W-1:0];
                            key_in_ready <= 1'b1;
                        end
                    end else begin
                        state_r      <= state_r;
                        key_in_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (len_ok_r && (crc_s == KEY_SIG)) begin
                        state_r      <= ARMED;
                        key_out      <= shadow_r;
                        key_armed    <= 1'b1;
                        fail_count   <= {FC_W{1'b0}};
                        key_in_ready <= 1'b1;
                    end else begin
                        fail_count <= fail_inc_s;
                        key_out    <= {KEY_W{1'b0}};
                        key_armed  <= 1'b0;
                        if (fail_inc_s == FC_W'(MAX_ATTEMPTS)) begin
                            state_r      <= LOCKOUT;
                            locked_out   <= 1'b1;
                            key_in_ready <= 1'b0;
                        end else begin
                            state_r      <= IDLE;
                            key_in_ready <= 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    state_r      <= LOCKOUT;
                    key_out      <= {KEY_W{1'b0}};
                    key_armed    <= 1'b0;
                    locked_out   <= 1'b1;
                    key_in_ready <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= {CNT_W{1'b0}};
                    key_out      <= {KEY_W{1'b0}};
                    key_armed    <= 1'b0;
                    key_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_key_ctrl.sv
// Directed bench for lock_key_ctrl: serial (1-bit) instance plus a 6-bit chunk instance.
module tb_lock_key_ctrl;

    function automatic logic [7:0] crc8_model(input logic [17:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 17; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    localparam logic [7:0] SIG = crc8_model(18'h2A5C3);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        valid0 = 1'b0, last0 = 1'b0, ready0;
    logic [0:0]  data0 = 1'b0;
    logic [17:0] key0;
    logic        armed0, locked0;
    logic [1:0]  fail0;

    logic        valid1 = 1'b0, last1 = 1'b0, ready1;
    logic [5:0]  data1 = 6'h00;
    logic [17:0] key1;
    logic        armed1, locked1;
    logic [1:0]  fail1;

    int total = 0;
    int bad   = 0;

    logic [17:0] good_key = 18'h2A5C3;
    logic [17:0] bad_key  = 18'h2A5C2;

    always #5 clk = ~clk;

    lock_key_ctrl #(.KEY_SIG(SIG)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .key_in_valid(valid0), .key_in_ready(ready0), .key_in_data(data0), .key_in_last(last0),
        .key_out(key0), .key_armed(armed0), .locked_out(locked0), .fail_count(fail0)
    );

    lock_key_ctrl #(.CHUNK_W(6), .KEY_SIG(SIG)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .key_in_valid(valid1), .key_in_ready(ready1), .key_in_data(data1), .key_in_last(last1),
        .key_out(key1), .key_armed(armed1), .locked_out(locked1), .fail_count(fail1)
    );

    task automatic send_chunk(input logic d, input logic l);
        int w;
        w = 0;
        while (!ready0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        total++;
        if (ready0 !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait: ready=%b want 1", ready0);
        end
        valid0 = 1'b1; data0 = d; last0 = l;
        @(posedge clk); #1;
        valid0 = 1'b0; last0 = 1'b0;
    endtask

    task automatic send_key(input logic [17:0] k, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            send_chunk(k[17-i], (i == last_idx));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (key0 !== 18'h00000) begin bad++; $display("FAIL rst_key: got %h want 00000", key0); end
        total++; if ({armed0, locked0, fail0} !== 4'b0000) begin bad++; $display("FAIL rst_flags: got %b want 0000", {armed0, locked0, fail0}); end
        @(posedge clk); #1 rst_n = 1'b1;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL rst_ready_pre: got %b want 0", ready0); end
        @(posedge clk); #1;
        total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL rst_ready_post: got %b want 1", ready0); end
    endtask

    task automatic check_arm(input string name);
        total++; if (armed0 !== 1'b0 || ready0 !== 1'b0) begin bad++; $display("FAIL %s_check_cycle: armed=%b ready=%b want 0 0", name, armed0, ready0); end
        @(posedge clk); #1;
        total++; if (armed0 !== 1'b1) begin bad++; $display("FAIL %s_armed: got %b want 1", name, armed0); end
        total++; if (key0 !== 18'h2A5C3) begin bad++; $display("FAIL %s_key: got %h want 2a5c3", name, key0); end
        total++; if (fail0 !== 2'd0) begin bad++; $display("FAIL %s_fail: got %0d want 0", name, fail0); end
    endtask

    task automatic test_pass();
        send_key(good_key, 18, 17);
        check_arm("pass");
    endtask

    task automatic test_rearm();
        send_chunk(good_key[17], 1'b0);
        total++; if (key0 !== 18'h00000 || armed0 !== 1'b0) begin bad++; $display("FAIL rearm_clear: key=%h armed=%b want 00000 0", key0, armed0); end
        for (int i = 1; i < 18; i++) send_chunk(good_key[17-i], (i == 17));
        check_arm("rearm");
    endtask

    task automatic test_length();
        send_key(good_key, 10, 9);
        @(posedge clk); #1;
        total++; if (fail0 !== 2'd1) begin bad++; $display("FAIL short_fail: got %0d want 1", fail0); end
        total++; if (key0 !== 18'h00000 || armed0 !== 1'b0 || ready0 !== 1'b1) begin bad++; $display("FAIL short_idle: key=%h armed=%b ready=%b want 00000 0 1", key0, armed0, ready0); end
        send_key(good_key, 18, 17);
        check_arm("short_recover");
        send_key(good_key, 19, -1);
        @(posedge clk); #1;
        total++; if (fail0 !== 2'd1 || armed0 !== 1'b0) begin bad++; $display("FAIL long_fail: fail=%0d armed=%b want 1 0", fail0, armed0); end
        send_key(good_key, 18, 17);
        check_arm("long_recover");
    endtask

    task automatic test_reset_midload();
        send_key(good_key, 9, -1);
        #3 rst_n = 1'b0;
        #1;
        total++; if ({key0, armed0, locked0, fail0, ready0} !== 23'h0) begin bad++; $display("FAIL midrst_zero: key=%h armed=%b locked=%b fail=%0d ready=%b want all 0", key0, armed0, locked0, fail0, ready0); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_key(good_key, 18, 17);
        check_arm("midrst_load");
    endtask

    task automatic test_lockout();
        for (int k = 1; k <= 3; k++) begin
            send_key(bad_key, 18, 17);
            @(posedge clk); #1;
            total++; if (fail0 !== 2'(k)) begin bad++; $display("FAIL lock_count%0d: got %0d want %0d", k, fail0, k); end
            total++; if (locked0 !== (k == 3)) begin bad++; $display("FAIL lock_flag%0d: got %b want %b", k, locked0, (k == 3)); end
            total++; if (key0 !== 18'h00000) begin bad++; $display("FAIL lock_key%0d: got %h want 00000", k, key0); end
        end
        valid0 = 1'b1; data0 = 1'b1; last0 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (ready0 !== 1'b0 || fail0 !== 2'd3 || locked0 !== 1'b1) begin bad++; $display("FAIL lock_hold: ready=%b fail=%0d locked=%b want 0 3 1", ready0, fail0, locked0); end
        end
        valid0 = 1'b0; last0 = 1'b0;
        rst_n = 1'b0; #1;
        total++; if (locked0 !== 1'b0 || fail0 !== 2'd0) begin bad++; $display("FAIL lock_clear: locked=%b fail=%0d want 0 0", locked0, fail0); end
        do_reset();
    endtask

    task automatic test_chunk6();
        logic [5:0] chunks [3];
        chunks[0] = 6'h2A; chunks[1] = 6'h17; chunks[2] = 6'h03;
        total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL c6_ready: got %b want 1", ready1); end
        for (int i = 0; i < 3; i++) begin
            valid1 = 1'b1; data1 = chunks[i]; last1 = (i == 2);
            @(posedge clk); #1;
        end
        valid1 = 1'b0; last1 = 1'b0;
        total++; if (armed1 !== 1'b0) begin bad++; $display("FAIL c6_check: armed=%b want 0", armed1); end
        @(posedge clk); #1;
        total++; if (key1 !== 18'h2A5C3 || armed1 !== 1'b1) begin bad++; $display("FAIL c6_armed: key=%h armed=%b want 2a5c3 1", key1, armed1); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_rearm();
        test_length();
        test_reset_midload();
        test_lockout();
        test_chunk6();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
